// File: rtl/register_file_scoreboard.sv
// Integer register file with a busy scoreboard: writeback port in, decode
// operand request/response out, with write-to-read bypass and RAW/WAW stalls.
module register_file_scoreboard #(
  parameter int REGISTER_WIDTH = 32,
  parameter int REGISTER_DEPTH = 32,
  localparam int AW = $clog2(REGISTER_DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_enable,
  input  logic [AW-1:0]             wr_address,
  input  logic [REGISTER_WIDTH-1:0] wr_data,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [AW-1:0]             req_rs1,
  input  logic [AW-1:0]             req_rs2,
  input  logic [AW-1:0]             req_rd,
  input  logic                      req_rd_enable,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [REGISTER_WIDTH-1:0] rsp_rs1_data,
  output logic [REGISTER_WIDTH-1:0] rsp_rs2_data,
  input  logic                      flush,
  output logic [REGISTER_DEPTH-1:0] busy
);

  logic [REGISTER_WIDTH-1:0] regs [REGISTER_DEPTH];
  logic [REGISTER_DEPTH-1:0] busy_next;
  logic [REGISTER_WIDTH-1:0] rs1_value, rs2_value;
  logic                      wr_live;
  logic                      hit_rs1, hit_rs2, hit_rd;
  logic                      haz_rs1, haz_rs2, waw;
  logic                      accept;

  // Index 0 is hardwired, so a write there never counts as a hit.
  assign wr_live = wr_enable && (wr_address != '0);
  assign hit_rs1 = wr_live && (wr_address == req_rs1);
  assign hit_rs2 = wr_live && (wr_address == req_rs2);
  assign hit_rd  = wr_live && (wr_address == req_rd);

  // A same-cycle write to a busy source releases the hazard immediately.
  assign haz_rs1 = (req_rs1 != '0) && busy[req_rs1] && !hit_rs1;
  assign haz_rs2 = (req_rs2 != '0) && busy[req_rs2] && !hit_rs2;
  assign waw     = req_rd_enable && (req_rd != '0) && busy[req_rd] && !hit_rd;

  assign req_ready = !flush && !haz_rs1 && !haz_rs2 && !waw
                     && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    rs1_value = regs[req_rs1];
    rs2_value = regs[req_rs2];
    if (req_rs1 == '0)  rs1_value = '0;
    else if (hit_rs1)   rs1_value = wr_data;
    if (req_rs2 == '0)  rs2_value = '0;
    else if (hit_rs2)   rs2_value = wr_data;
  end

  // Reservation is applied after the writeback clear so a same-index set wins.
  always_comb begin
    busy_next = busy;
    if (flush) begin
      busy_next = '0;
    end else begin
      if (wr_live) busy_next[wr_address] = 1'b0;
      if (accept && req_rd_enable && (req_rd != '0)) busy_next[req_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // NOTE: the register array is reset because a post-reset read must see zeros.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < REGISTER_DEPTH; i++) regs[i] <= '0;
    end else if (wr_live) begin
      // NOTE: state is updated with non-blocking assignments only.
      regs[wr_address] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_next;
  end

  // Response holds until consumed; an accept on the consuming edge replaces it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid    <= 1'b0;
      rsp_rs1_data <= '0;
      rsp_rs2_data <= '0;
    end else if (flush) begin
      rsp_valid <= 1'b0;
    end else if (accept) begin
      rsp_valid    <= 1'b1;
      rsp_rs1_data <= rs1_value;
      rsp_rs2_data <= rs2_value;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: doc/register_file_scoreboard.md
# register_file_scoreboard

Integer register file with scoreboard, the receiving end of the writeback stage's register write port (address/data/enable). It serves decode with two registered read operands through a valid/ready request/response pair. It tracks in-flight destination registers in a busy scoreboard so decode stalls on RAW/WAW hazards. Writeback updates are bypassed to same-cycle reads and clear the matching busy bit.

## Interface
- REGISTER_WIDTH, 32, data width of each register
- REGISTER_DEPTH, 32, number of registers; index width AW = $clog2(REGISTER_DEPTH)

- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-low
- wr_enable  in  1  writeback write strobe
- wr_address  in  AW  writeback destination index
- wr_data  in  REGISTER_WIDTH  writeback data
- req_valid  in  1  decode read/reserve request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_rs1, req_rs2  in  AW  source indices
- req_rd  in  AW  destination to reserve
- req_rd_enable  in  1  reserve req_rd on accept
- rsp_valid  out  1  operand response valid
- rsp_ready  in  1  consumer accepts response
- rsp_rs1_data, rsp_rs2_data  out  REGISTER_WIDTH  operand values
- flush  in  1  synchronous pipeline flush
- busy  out  REGISTER_DEPTH  scoreboard vector, bit i = register i reserved

## Operation
- Storage: REGISTER_DEPTH x REGISTER_WIDTH flops. Register 0 always reads 0. Writes to index 0 are discarded. busy[0] is never set.
- Write: wr_enable && wr_address != 0 updates the register and clears busy[wr_address] at the edge. Writing a non-busy register is legal.
- wr_hit(x) = wr_enable && wr_address == x && x != 0.
- src_hazard(x) = x != 0 && busy[x] && !wr_hit(x).
- waw = req_rd_enable && src_hazard(req_rd).
- req_ready = !flush && !src_hazard(req_rs1) && !src_hazard(req_rs2) && !waw && (!rsp_valid || rsp_ready). It is combinational and depends on req_* (ready-after-valid is acceptable to decode).
- Accept: each operand register loads 0 if index 0, else wr_data if wr_hit, else stored value. rsp_valid is set.
- Reserve on accept, when req_rd_enable && req_rd != 0: busy[req_rd] is set. If a write clears the same index in the same cycle, the set wins.
- Response: rsp_valid and the data stay stable until rsp_ready. rsp_valid clears on rsp_ready when no new accept occurs. Accept together with rsp_ready replaces the response (back-to-back).
- Flush (highest priority):
  - all busy bits clear;
  - rsp_valid clears;
  - no request is accepted.
  - A register write in the flush cycle still updates storage.
- Reset (rst low, asynchronous): all registers 0, busy 0, rsp_valid 0, rsp data 0. req_ready then follows its equation, so it is 1 whenever no request hazard exists.
- Reset released mid-operation: no retained state; the first accept after release sees zeros.

## Timing
- Request-to-response latency: 1 cycle. Accept at edge N gives rsp_valid high after edge N.
- Throughput: one request per cycle while rsp_ready = 1 and no hazard.
- Write-to-read: a write in cycle N is visible to a request accepted in cycle N (bypass) and all later ones.
- Busy release: a stalled request whose blocking source is written in cycle N has req_ready high in cycle N and is accepted in that cycle.
- Busy set: a reservation accepted at edge N makes busy[rd] visible from cycle N+1. A dependent request in cycle N+1 stalls.
- Backpressure: rsp_valid && !rsp_ready forces req_ready = 0 and holds rsp data.

## Test plan
- Reset then write: write x5 = 0x0000_00AA, then request rs1 = 5, rs2 = 0. Required: one cycle later rsp_rs1_data = 0xAA, rsp_rs2_data = 0.
- x0 immunity: write x0 = 0xFFFF_FFFF with reserve rd = 0, then read rs1 = 0. Required: data 0 and busy = 0.
- RAW stall/release: reserve rd = 7, then request rs2 = 7. Required: req_ready = 0 until the cycle wr_enable writes x7 = 0x1234. In that cycle it is accepted, and rsp_rs2_data = 0x1234 (bypass) with busy[7] = 0.
- WAW plus same-cycle set/clear:
  - With x3 busy, a request reserving rd = 3 stalls.
  - In the cycle x3 is written, the request is accepted and busy[3] remains 1.
- Backpressure: hold rsp_ready = 0 for 3 cycles after an accept. Required: rsp data is stable, req_ready = 0 throughout, and a pending request is accepted in the cycle rsp_ready rises.
- Flush/reset mid-operation:
  - With busy = {x4, x9} and rsp_valid = 1, pulse flush. Required: busy = 0, rsp_valid = 0, and no accept that cycle.
  - Then drop rst asynchronously mid-cycle. Required: outputs reach reset values immediately.
